// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register busy scoreboard, x0 hardwired to zero.
// Define REG_FILE_SB_BYPASS_EN for write-first forwarding onto the read ports.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic              busy1,
  output logic              busy2,
  input  logic              write_ctr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              wr_err
);
  localparam int DEPTH = 2**ADDR_W;
  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic              r_wr_err;
  logic              w_we, w_rsv;
  assign w_we  = write_ctr && write_addr != '0;
  assign w_rsv = rsv_en && rsv_addr != '0;
  // Reserve is applied after the write so a same-address issue leaves busy set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_rf[i] <= '0;
      r_busy   <= '0;
      r_wr_err <= 1'b0;
    end else begin
      if (w_we) begin
        r_rf[write_addr]   <= write_data;
        r_busy[write_addr] <= 1'b0;
        if (!r_busy[write_addr]) r_wr_err <= 1'b1;
      end
      if (w_rsv) r_busy[rsv_addr] <= 1'b1;
    end
  end
  assign wr_err = r_wr_err;
`ifdef REG_FILE_SB_BYPASS_EN
  logic w_hit1, w_hit2, w_fwd_busy;
  assign w_hit1     = w_we && !rst && read1 == write_addr;
  assign w_hit2     = w_we && !rst && read2 == write_addr;
  assign w_fwd_busy = w_rsv && rsv_addr == write_addr;
  assign out1  = w_hit1 ? write_data : r_rf[read1];
  assign out2  = w_hit2 ? write_data : r_rf[read2];
  assign busy1 = w_hit1 ? w_fwd_busy : r_busy[read1];
  assign busy2 = w_hit2 ? w_fwd_busy : r_busy[read2];
`else
  assign out1  = r_rf[read1];
  assign out2  = r_rf[read2];
  assign busy1 = r_busy[read1];
  assign busy2 = r_busy[read2];
`endif
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb; expected read-port state is queued then compared.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  read1 = '0, read2 = '0, write_addr = '0, rsv_addr = '0;
  logic [31:0] write_data = '0;
  logic        write_ctr = 1'b0, rsv_en = 1'b0;
  logic [31:0] out1, out2;
  logic        busy1, busy2, wr_err;
  logic [31:0] mdl [32];
  logic [31:0] mbusy;
  logic        merr;
  logic [66:0] q [$];
  logic [66:0] e, got;
  int          total = 0, bad = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .read1(read1), .read2(read2), .out1(out1), .out2(out2),
    .busy1(busy1), .busy2(busy2), .write_ctr(write_ctr), .write_addr(write_addr),
    .write_data(write_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mbusy = '0;
    merr  = 1'b0;
  endtask

  // Expected {out1,busy1,out2,busy2,wr_err} for the current inputs and model state.
  function automatic logic [66:0] exp_now();
    logic [31:0] d1, d2;
    logic b1, b2;
    d1 = mdl[read1]; b1 = mbusy[read1];
    d2 = mdl[read2]; b2 = mbusy[read2];
`ifdef REG_FILE_SB_BYPASS_EN
    if (write_ctr && write_addr != 0 && read1 == write_addr) begin
      d1 = write_data; b1 = rsv_en && rsv_addr == write_addr;
    end
    if (write_ctr && write_addr != 0 && read2 == write_addr) begin
      d2 = write_data; b2 = rsv_en && rsv_addr == write_addr;
    end
`endif
    if (rst) begin d1 = '0; b1 = 1'b0; d2 = '0; b2 = 1'b0; end
    return {d1, b1, d2, b2, merr};
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re, input logic [4:0] ra);
    write_ctr = we; write_addr = wa; write_data = wd; rsv_en = re; rsv_addr = ra;
  endtask

  task automatic commit();
    if (!rst) begin
      if (write_ctr && write_addr != 0) begin
        if (!mbusy[write_addr]) merr = 1'b1;
        mdl[write_addr]   = write_data;
        mbusy[write_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) mbusy[rsv_addr] = 1'b1;
    end
    @(posedge clk); #1;
    write_ctr = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    model_clear();
    read1 = 5'd5; read2 = 5'd0;
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_initial got=%h want=%h", got, e); end
    @(posedge clk); #1; rst = 1'b0;
    drive(1, 5'd5, 32'hDEADBEEF, 0, 0); commit();
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_prewrite got=%h want=%h", got, e); end
    drive(1, 5'd5, 32'h11111111, 1, 5'd6);
    rst = 1'b1; model_clear(); read2 = 5'd6;
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_held got=%h want=%h", got, e); end
    commit();
    rst = 1'b0;
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_after got=%h want=%h", got, e); end
  endtask

  task automatic test_x0();
    drive(0, 0, 0, 1, 5'd0); commit();
    drive(1, 5'd0, 32'h1234, 0, 0);
    read1 = 5'd0; read2 = 5'd0;
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL x0_same_cycle got=%h want=%h", got, e); end
    commit();
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL x0_after got=%h want=%h", got, e); end
  endtask

  task automatic test_scoreboard();
    read1 = 5'd7; read2 = 5'd0;
    drive(0, 0, 0, 1, 5'd7); commit();
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL sb_reserved got=%h want=%h", got, e); end
    drive(1, 5'd7, 32'hA5A5A5A5, 0, 0); commit();
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL sb_written got=%h want=%h", got, e); end
  endtask

  task automatic test_collision();
    read1 = 5'd9; read2 = 5'd9;
    drive(0, 0, 0, 1, 5'd9); commit();
    drive(1, 5'd9, 32'h55, 1, 5'd9);
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL collide_same_cycle got=%h want=%h", got, e); end
    commit();
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL collide_after got=%h want=%h", got, e); end
  endtask

  task automatic test_bypass();
    read1 = 5'd12; read2 = 5'd12;
    drive(0, 0, 0, 1, 5'd12); commit();
    drive(1, 5'd12, 32'h0BAD0BAD, 0, 0); commit();
    drive(0, 0, 0, 1, 5'd12); commit();
    drive(1, 5'd12, 32'hCAFEF00D, 0, 0);
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL bypass_same_cycle got=%h want=%h", got, e); end
    commit();
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL bypass_next_cycle got=%h want=%h", got, e); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] a, p;
    p = 5'd16;
    drive(0, 0, 0, 1, p); commit();
    for (int i = 1; i < 9; i++) begin
      a = 5'(16 + i);
      drive(1, p, $urandom, i < 8, a);
      read1 = p; read2 = a;
      q.push_back(exp_now());
      #1;
      got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL b2b_same_cycle i=%0d got=%h want=%h", i, got, e); end
      commit();
      q.push_back(exp_now()); #1;
      got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL b2b_after i=%0d got=%h want=%h", i, got, e); end
      p = a;
    end
  endtask

  task automatic test_stray();
    read1 = 5'd3; read2 = 5'd7;
    drive(1, 5'd3, 32'h77, 0, 0); commit();
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL stray_set got=%h want=%h", got, e); end
    drive(0, 0, 0, 1, 5'd3); commit();
    drive(1, 5'd3, 32'h88, 0, 0); commit();
    commit();
    q.push_back(exp_now()); #1;
    got = {out1, busy1, out2, busy2, wr_err}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL stray_sticky got=%h want=%h", got, e); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_back_to_back();
    test_stray();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
